// File: rtl/frame_transmitter.sv
// Transmit-side framer for the 16-bit transceiver link.
// Packs a valid/ready sample stream into fixed-length frames:
// start word, time stamp, payload words, end word.
// Idle K-words are sent whenever no frame is running or the link is down.
module frame_transmitter #(
  parameter int unsigned FRAME_LEN  = 128,
  parameter logic [15:0] START_WORD = 16'hDEAD,
  parameter logic [15:0] END_WORD   = 16'hBEEF,
  parameter logic [15:0] IDLE_WORD  = 16'hFF00,
  parameter logic [1:0]  IDLE_DATAK = 2'b01,
  parameter logic [15:0] FILL_WORD  = 16'h0000
) (
  input  logic        tx_std_clkout,
  input  logic        rst,
  input  logic        tx_link_ready,
  input  logic        enable,
  input  logic [15:0] sample_data,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic [15:0] tx_parallel_data,
  output logic [1:0]  tx_datak,
  output logic        frame_active,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic [15:0] underrun_count
);

  // Number of payload words between the time stamp and the end word.
  localparam logic [9:0] PAY_LEN = 10'(FRAME_LEN - 3);

  // The state names the kind of word currently on the output. EOF means the
  // last payload word is out and the end word goes next; the end word itself
  // is emitted while already back in IDLE so a new frame can follow at once.
  typedef enum logic [2:0] {
    IDLE,
    SOF,
    TS,
    PAYLOAD,
    EOF
  } state_t;

  state_t      r_state;
  logic [9:0]  r_payCnt;
  logic [15:0] r_txData;
  logic [1:0]  r_txDatak;
  logic        r_frameActive;
  logic        r_frameDone;
  logic [15:0] r_frameCount;
  logic [15:0] r_underrunCount;

  state_t      w_nextState;
  logic [9:0]  w_nextPayCnt;
  logic [15:0] w_nextTxData;
  logic [1:0]  w_nextTxDatak;
  logic        w_nextFrameActive;
  logic        w_nextFrameDone;
  logic [15:0] w_nextFrameCount;
  logic [15:0] w_nextUnderrunCount;
  logic        w_sampleReady;

  // Samples are taken only in the cycles whose next output is a payload word,
  // and never while the link is down.
  assign w_sampleReady = tx_link_ready && ((r_state == TS) || (r_state == PAYLOAD));

  assign sample_ready     = w_sampleReady;
  assign tx_parallel_data = r_txData;
  assign tx_datak         = r_txDatak;
  assign frame_active     = r_frameActive;
  assign frame_done       = r_frameDone;
  assign frame_count      = r_frameCount;
  assign underrun_count   = r_underrunCount;

  // Next-state and next-output decode; anything not explicitly a frame word
  // falls back to the idle K-word.
  always_comb begin
    w_nextState         = r_state;
    w_nextPayCnt        = r_payCnt;
    w_nextTxData        = IDLE_WORD;
    w_nextTxDatak       = IDLE_DATAK;
    w_nextFrameActive   = 1'b0;
    w_nextFrameDone     = 1'b0;
    w_nextFrameCount    = r_frameCount;
    w_nextUnderrunCount = r_underrunCount;
    unique case (r_state)
      IDLE: begin
        if (enable && tx_link_ready && sample_valid) begin
          w_nextState       = SOF;
          w_nextTxData      = START_WORD;
          w_nextTxDatak     = 2'b00;
          w_nextFrameActive = 1'b1;
        end
      end
      SOF: begin
        if (tx_link_ready) begin
          w_nextState       = TS;
          w_nextTxData      = r_frameCount;
          w_nextTxDatak     = 2'b00;
          w_nextFrameActive = 1'b1;
          w_nextFrameCount  = r_frameCount + 16'd1;
        end else begin
          w_nextState = IDLE;
        end
      end
      TS, PAYLOAD: begin
        if (tx_link_ready) begin
          w_nextPayCnt      = (r_state == TS) ? 10'd1 : (r_payCnt + 10'd1);
          w_nextTxDatak     = 2'b00;
          w_nextFrameActive = 1'b1;
          if (sample_valid) begin
            w_nextTxData = sample_data;
          end else begin
            w_nextTxData = FILL_WORD;
            if (r_underrunCount != 16'hFFFF) begin
              w_nextUnderrunCount = r_underrunCount + 16'd1;
            end
          end
          w_nextState = (w_nextPayCnt == PAY_LEN) ? EOF : PAYLOAD;
        end else begin
          w_nextState = IDLE;
        end
      end
      EOF: begin
        w_nextState = IDLE;
        if (tx_link_ready) begin
          w_nextTxData      = END_WORD;
          w_nextTxDatak     = 2'b00;
          w_nextFrameActive = 1'b1;
          w_nextFrameDone   = 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in progress.
  always_ff @(posedge tx_std_clkout) begin
    if (rst) begin
      r_state         <= IDLE;
      r_payCnt        <= 10'd0;
      r_txData        <= IDLE_WORD;
      r_txDatak       <= IDLE_DATAK;
      r_frameActive   <= 1'b0;
      r_frameDone     <= 1'b0;
      r_frameCount    <= 16'd0;
      r_underrunCount <= 16'd0;
    end else begin
      r_state         <= w_nextState;
      r_payCnt        <= w_nextPayCnt;
      r_txData        <= w_nextTxData;
      r_txDatak       <= w_nextTxDatak;
      r_frameActive   <= w_nextFrameActive;
      r_frameDone     <= w_nextFrameDone;
      r_frameCount    <= w_nextFrameCount;
      r_underrunCount <= w_nextUnderrunCount;
    end
  end

endmodule

// File: tb/tb_frame_transmitter.sv
// Directed testbench for frame_transmitter with the default 128-word frame.
// Inputs change 1 ns after each rising edge and outputs are checked there.
module tb_frame_transmitter;

  logic        clk;
  logic        rst;
  logic        linkReady;
  logic        enable;
  logic [15:0] sampleData;
  logic        sampleValid;
  logic        sampleReady;
  logic [15:0] txData;
  logic [1:0]  txDatak;
  logic        frameActive;
  logic        frameDone;
  logic [15:0] frameCount;
  logic [15:0] underrunCount;

  int assertCount = 0;
  int failCount   = 0;
  int cycleNo     = 0;
  int lastDoneCycle = 0;
  int donePulses  = 0;

  frame_transmitter dut (
    .tx_std_clkout    (clk),
    .rst              (rst),
    .tx_link_ready    (linkReady),
    .enable           (enable),
    .sample_data      (sampleData),
    .sample_valid     (sampleValid),
    .sample_ready     (sampleReady),
    .tx_parallel_data (txData),
    .tx_datak         (txDatak),
    .frame_active     (frameActive),
    .frame_done       (frameDone),
    .frame_count      (frameCount),
    .underrun_count   (underrunCount)
  );

  // 100 MHz transmit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cycleNo++;
  endtask

  // Reset, then twenty idle cycles with the link down.
  task automatic test_reset();
    rst = 1'b1; linkReady = 1'b0; enable = 1'b0; sampleValid = 1'b0; sampleData = 16'h0;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      assertCount++;
      if (txData !== 16'hFF00 || txDatak !== 2'b01) begin
        failCount++; $display("[TB] FAIL reset_idle_word cyc %0d: got %h/%b, want ff00/01", i, txData, txDatak);
      end
      assertCount++;
      if (sampleReady !== 1'b0 || frameActive !== 1'b0 || frameDone !== 1'b0) begin
        failCount++; $display("[TB] FAIL reset_flags cyc %0d: rdy/act/done %b%b%b, want 000", i, sampleReady, frameActive, frameDone);
      end
    end
    assertCount++;
    if (frameCount !== 16'd0 || underrunCount !== 16'd0) begin
      failCount++; $display("[TB] FAIL reset_counters: got %h/%h, want 0000/0000", frameCount, underrunCount);
    end
  endtask

  // One full frame with incrementing samples; start condition is left true.
  task automatic test_single_frame();
    logic [15:0] expData;
    logic        expReady;
    linkReady = 1'b1; enable = 1'b1; sampleValid = 1'b1; sampleData = 16'h0001;
    #1;
    assertCount++;
    if (sampleReady !== 1'b0) begin
      failCount++; $display("[TB] FAIL single_ready_idle: got %b, want 0", sampleReady);
    end
    for (int k = 1; k <= 128; k++) begin
      step();
      if (k >= 2) sampleData = 16'(k - 1);
      if (k == 1)        expData = 16'hDEAD;
      else if (k == 2)   expData = 16'h0000;
      else if (k == 128) expData = 16'hBEEF;
      else               expData = 16'(k - 2);
      expReady = (k >= 2) && (k <= 126);
      assertCount++;
      if (txData !== expData || txDatak !== 2'b00 || frameActive !== 1'b1) begin
        failCount++; $display("[TB] FAIL single_word k=%0d: got %h/%b act %b, want %h/00 act 1", k, txData, txDatak, frameActive, expData);
      end
      assertCount++;
      if (sampleReady !== expReady) begin
        failCount++; $display("[TB] FAIL single_ready k=%0d: got %b, want %b", k, sampleReady, expReady);
      end
      assertCount++;
      if (frameDone !== (k == 128)) begin
        failCount++; $display("[TB] FAIL single_done k=%0d: got %b, want %b", k, frameDone, (k == 128));
      end
      assertCount++;
      if (frameCount !== ((k >= 2) ? 16'd1 : 16'd0)) begin
        failCount++; $display("[TB] FAIL single_frame_count k=%0d: got %h", k, frameCount);
      end
      if (frameDone === 1'b1) begin
        donePulses++;
        lastDoneCycle = cycleNo;
      end
    end
  endtask

  // Three more frames following with no gap; enable dropped mid-frame in the last.
  task automatic test_back_to_back();
    for (int f = 1; f <= 3; f++) begin
      for (int k = 1; k <= 128; k++) begin
        step();
        if (f == 3 && k == 50) enable = 1'b0;
        if (k == 1) begin
          assertCount++;
          if (txData !== 16'hDEAD || frameActive !== 1'b1) begin
            failCount++; $display("[TB] FAIL b2b_start f=%0d: got %h act %b, want dead act 1", f, txData, frameActive);
          end
        end
        if (k == 2) begin
          assertCount++;
          if (txData !== 16'(f) || frameCount !== 16'(f + 1)) begin
            failCount++; $display("[TB] FAIL b2b_stamp f=%0d: got %h cnt %h, want %h cnt %h", f, txData, frameCount, 16'(f), 16'(f + 1));
          end
        end
        if (k == 128) begin
          assertCount++;
          if (txData !== 16'hBEEF) begin
            failCount++; $display("[TB] FAIL b2b_end f=%0d: got %h, want beef", f, txData);
          end
        end
        assertCount++;
        if (frameDone !== (k == 128)) begin
          failCount++; $display("[TB] FAIL b2b_done f=%0d k=%0d: got %b, want %b", f, k, frameDone, (k == 128));
        end
        if (frameDone === 1'b1) begin
          assertCount++;
          if (cycleNo - lastDoneCycle != 128) begin
            failCount++; $display("[TB] FAIL b2b_spacing f=%0d: got %0d cycles, want 128", f, cycleNo - lastDoneCycle);
          end
          donePulses++;
          lastDoneCycle = cycleNo;
        end
      end
    end
    step();
    assertCount++;
    if (txData !== 16'hFF00 || txDatak !== 2'b01 || frameActive !== 1'b0) begin
      failCount++; $display("[TB] FAIL b2b_idle_after: got %h/%b act %b, want ff00/01 act 0", txData, txDatak, frameActive);
    end
    assertCount++;
    if (donePulses != 4 || frameCount !== 16'd4) begin
      failCount++; $display("[TB] FAIL b2b_totals: pulses %0d cnt %h, want 4 cnt 0004", donePulses, frameCount);
    end
  endtask

  // Three missing samples mid-payload become fill words; payload equal to
  // the start word passes through untouched.
  task automatic test_underrun();
    logic [15:0] expData;
    enable = 1'b1; sampleValid = 1'b1; sampleData = 16'hDEAD; linkReady = 1'b1;
    for (int k = 1; k <= 128; k++) begin
      step();
      if (k == 1) enable = 1'b0;
      sampleValid = !(k >= 50 && k <= 52);
      if (k == 1)                    expData = 16'hDEAD;
      else if (k == 2)               expData = 16'h0004;
      else if (k == 128)             expData = 16'hBEEF;
      else if (k >= 51 && k <= 53)   expData = 16'h0000;
      else                           expData = 16'hDEAD;
      assertCount++;
      if (txData !== expData || txDatak !== 2'b00) begin
        failCount++; $display("[TB] FAIL underrun_word k=%0d: got %h/%b, want %h/00", k, txData, txDatak, expData);
      end
      assertCount++;
      if (frameDone !== (k == 128)) begin
        failCount++; $display("[TB] FAIL underrun_done k=%0d: got %b, want %b", k, frameDone, (k == 128));
      end
    end
    assertCount++;
    if (underrunCount !== 16'd3) begin
      failCount++; $display("[TB] FAIL underrun_count: got %h, want 0003", underrunCount);
    end
    step();
    assertCount++;
    if (txData !== 16'hFF00 || frameCount !== 16'd5) begin
      failCount++; $display("[TB] FAIL underrun_idle_after: got %h cnt %h, want ff00 cnt 0005", txData, frameCount);
    end
  endtask

  // Link drops at payload word 50, frame is abandoned, a new one follows.
  task automatic test_link_loss();
    enable = 1'b1; sampleValid = 1'b1; sampleData = 16'h5A5A; linkReady = 1'b1;
    for (int k = 1; k <= 52; k++) begin
      step();
      if (k == 1) enable = 1'b0;
      if (k == 2) begin
        assertCount++;
        if (txData !== 16'h0005) begin
          failCount++; $display("[TB] FAIL link_stamp: got %h, want 0005", txData);
        end
      end
    end
    assertCount++;
    if (txData !== 16'h5A5A || sampleReady !== 1'b1) begin
      failCount++; $display("[TB] FAIL link_word50: got %h rdy %b, want 5a5a rdy 1", txData, sampleReady);
    end
    linkReady = 1'b0;
    #1;
    assertCount++;
    if (sampleReady !== 1'b0) begin
      failCount++; $display("[TB] FAIL link_ready_drop: got %b, want 0", sampleReady);
    end
    step();
    assertCount++;
    if (txData !== 16'hFF00 || txDatak !== 2'b01 || frameActive !== 1'b0 || frameDone !== 1'b0) begin
      failCount++; $display("[TB] FAIL link_idle: got %h/%b act %b done %b, want ff00/01 0 0", txData, txDatak, frameActive, frameDone);
    end
    assertCount++;
    if (frameCount !== 16'd6) begin
      failCount++; $display("[TB] FAIL link_count_kept: got %h, want 0006", frameCount);
    end
    for (int i = 0; i < 130; i++) begin
      step();
      assertCount++;
      if (txData !== 16'hFF00 || frameDone !== 1'b0) begin
        failCount++; $display("[TB] FAIL link_no_end cyc %0d: got %h done %b, want ff00 done 0", i, txData, frameDone);
      end
    end
    linkReady = 1'b1; enable = 1'b1;
    step();
    enable = 1'b0;
    assertCount++;
    if (txData !== 16'hDEAD) begin
      failCount++; $display("[TB] FAIL link_restart: got %h, want dead", txData);
    end
    step();
    assertCount++;
    if (txData !== 16'h0006 || frameCount !== 16'd7) begin
      failCount++; $display("[TB] FAIL link_restart_stamp: got %h cnt %h, want 0006 cnt 0007", txData, frameCount);
    end
    for (int k = 3; k <= 128; k++) step();
    assertCount++;
    if (txData !== 16'hBEEF || frameDone !== 1'b1) begin
      failCount++; $display("[TB] FAIL link_restart_end: got %h done %b, want beef done 1", txData, frameDone);
    end
    step();
  endtask

  // Reset at payload word 10 drops the frame and clears the counters.
  task automatic test_reset_mid_frame();
    enable = 1'b1; sampleValid = 1'b1; sampleData = 16'h0BAD; linkReady = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 1) enable = 1'b0;
      sampleValid = (k != 5);
    end
    assertCount++;
    if (txData !== 16'h0BAD || frameCount !== 16'd8 || underrunCount !== 16'd4) begin
      failCount++; $display("[TB] FAIL rstmid_before: got %h cnt %h und %h, want 0bad 0008 0004", txData, frameCount, underrunCount);
    end
    rst = 1'b1;
    step();
    assertCount++;
    if (txData !== 16'hFF00 || txDatak !== 2'b01 || frameActive !== 1'b0 || sampleReady !== 1'b0) begin
      failCount++; $display("[TB] FAIL rstmid_idle: got %h/%b act %b rdy %b, want ff00/01 0 0", txData, txDatak, frameActive, sampleReady);
    end
    assertCount++;
    if (frameCount !== 16'd0 || underrunCount !== 16'd0) begin
      failCount++; $display("[TB] FAIL rstmid_counters: got %h/%h, want 0000/0000", frameCount, underrunCount);
    end
    rst = 1'b0;
    for (int i = 0; i < 130; i++) begin
      step();
      assertCount++;
      if (txData !== 16'hFF00 || frameDone !== 1'b0) begin
        failCount++; $display("[TB] FAIL rstmid_no_end cyc %0d: got %h done %b", i, txData, frameDone);
      end
    end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_underrun();
    test_link_loss();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/frame_transmitter.md
Name: frame_transmitter

Overview:
- Transmit-side framer for the 16-bit transceiver data link; the counterpart of the thresholder/receive path.
- Takes a valid/ready sample stream and emits fixed-length frames toward the transceiver TX parallel interface: start word, time stamp, payload, end word.
- Emits K-character idle words whenever no frame is in progress or the link is not up.

Parameters:
- FRAME_LEN, 128: total words per frame including start, time stamp and end words; legal range 4..1024.
- START_WORD, 16'hDEAD: first word of every frame.
- END_WORD, 16'hBEEF: last word of every frame.
- IDLE_WORD, 16'hFF00: word sent outside frames.
- IDLE_DATAK, 2'b01: tx_datak value sent with IDLE_WORD.
- FILL_WORD, 16'h0000: payload word sent on sample underrun.

Ports:
- tx_std_clkout  in  1: transmit parallel clock; the single clock of the block.
- rst  in  1: synchronous, active-high reset.
- tx_link_ready  in  1: link up; all frames start and continue only while this is high.
- enable  in  1: frame generation enable, sampled only in IDLE.
- sample_data  in  16: payload sample.
- sample_valid  in  1: sample_data valid.
- sample_ready  out  1: block accepts sample_data this cycle.
- tx_parallel_data  out  16: registered word to the transceiver.
- tx_datak  out  2: registered K flags per byte; 2'b00 for all frame words.
- frame_active  out  1: high while a frame word is on tx_parallel_data.
- frame_done  out  1: one-cycle pulse coincident with END_WORD on the output.
- frame_count  out  16: time stamp of the next frame to be sent.
- underrun_count  out  16: number of FILL_WORD insertions, saturating at 16'hFFFF.

Behaviour:
- Reset (rst high at a clock edge):
  - tx_parallel_data=IDLE_WORD, tx_datak=IDLE_DATAK.
  - sample_ready=0, frame_active=0, frame_done=0.
  - frame_count=0, underrun_count=0, state=IDLE.
  - Reset mid-frame abandons the frame immediately; no END_WORD is sent.
- States: IDLE, SOF, TS, PAYLOAD, EOF. All outputs are registered.
- Start condition: state IDLE and enable & tx_link_ready & sample_valid sampled high at cycle T.
- Output sequence for a frame started at T:
  - T+1: START_WORD.
  - T+2: frame_count value (time stamp).
  - T+3 .. T+FRAME_LEN-1: FRAME_LEN-3 payload words (125 at default).
  - T+FRAME_LEN: END_WORD with frame_done=1.
- frame_count increments by 1 at the edge that places the time stamp on the output; wraps 16'hFFFF -> 16'h0000.
- Payload handshake:
  - sample_ready is high exactly in cycles T+2 .. T+FRAME_LEN-2. It is combinational from state and tx_link_ready, and low when tx_link_ready is low.
  - A sample accepted (valid & ready) at cycle k appears on tx_parallel_data at k+1.
  - If sample_valid is low in a ready cycle, FILL_WORD is sent at k+1 and underrun_count increments (saturating). Frame length never changes.
  - Payload values equal to START_WORD or END_WORD are passed unmodified; the receiver frames by position.
- Back-to-back frames: IDLE is entered on the edge that places END_WORD on the output. If the start condition holds in that same cycle, the next START_WORD follows END_WORD with no idle gap.
- Link loss: if tx_link_ready is low at any edge in SOF/TS/PAYLOAD/EOF, the next output is IDLE_WORD/IDLE_DATAK and the state is IDLE.
  - frame_active=0 and no frame_done pulse.
  - frame_count is not rolled back.
- enable deasserted mid-frame has no effect; the current frame completes.
- In IDLE: output is IDLE_WORD/IDLE_DATAK, frame_active=0.

Test Plan:
- Reset -> tx_parallel_data=16'hFF00, tx_datak=2'b01, sample_ready=0 for 20 cycles while tx_link_ready=0.
- Link up, enable=1, sample_valid always high, sample_data incrementing from 16'h0001 -> output DEAD, 0000, 0001..007D, BEEF. 128 words with tx_datak=00, then next frame starts immediately with time stamp 0001.
- Four consecutive frames -> time stamps 0000..0003, four frame_done pulses; the 128-cycle spacing between pulses holds only when the start condition is already true at each END_WORD cycle.
- sample_valid low for 3 cycles mid-payload -> three 16'h0000 payload words in place, underrun_count=3, END_WORD still at T+128.
- tx_link_ready dropped at payload word 50 -> next output FF00/01, no BEEF, frame_count stays incremented; a new frame starts after the link returns.
- rst asserted at payload word 10 -> idle word next cycle, frame_count=0, underrun_count=0.
